framebuffer_arbiter: RTL and testbench

FRAMEBUFFER_ARBITER -- requirements
Module: framebuffer_arbiter

---
 rtl/framebuffer_arbiter.sv | 164 ++++++++++++++++
 tb/tb_framebuffer_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/framebuffer_arbiter.sv
// Single-port framebuffer BRAM arbiter. Video fetch has absolute priority, then a
// full-buffer clear engine, then at most one outstanding CPU read, write or XOR.
module framebuffer_arbiter #(
    parameter int READ_LATENCY = 2
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       video_active_in,
    input  logic [7:0] video_addr_in,
    output logic [7:0] video_data_out,
    input  logic       cpu_req_valid_in,
    output logic       cpu_req_ready_out,
    input  logic [1:0] cpu_op_in,
    input  logic [7:0] cpu_addr_in,
    input  logic [7:0] cpu_wdata_in,
    output logic       cpu_rvalid_out,
    output logic [7:0] cpu_rdata_out,
    output logic       cpu_collision_out,
    input  logic       clear_start_in,
    output logic       clear_busy_out,
    output logic       clear_done_out,
    output logic [7:0] bram_addr_out,
    output logic       bram_we_out,
    output logic [7:0] bram_wdata_out,
    input  logic [7:0] bram_rdata_in
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, XOR_WB, CLEAR} state_t;

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_XOR   = 2'b10;

    state_t                  state;
    logic [7:0]              addr_q;
    logic [7:0]              wdata_q;
    logic [7:0]              old_q;
    logic [7:0]              clear_cnt;
    logic                    is_xor_q;
    logic                    clear_pending;
    logic                    busy_q;
    logic                    done_q;
    logic [READ_LATENCY-1:0] tag_q;

    logic accept;
    logic cpu_read_issue;
    logic rd_return;

    assign cpu_req_ready_out = (state == IDLE) && !video_active_in
                               && !clear_start_in && !clear_pending;
    assign accept            = cpu_req_ready_out && cpu_req_valid_in;
    assign cpu_read_issue    = accept && (cpu_op_in != OP_WRITE);

    // The oldest tag marks the cycle in which the CPU's read data is on bram_rdata_in.
    assign rd_return         = tag_q[READ_LATENCY-1];
    assign cpu_rvalid_out    = rd_return;
    assign cpu_rdata_out     = rd_return ? bram_rdata_in : 8'h00;
    assign cpu_collision_out = rd_return && is_xor_q && (|(bram_rdata_in & wdata_q));

    assign video_data_out    = bram_rdata_in;
    assign clear_busy_out    = busy_q;
    assign clear_done_out    = done_q;

    always_comb begin
        // NOTE: every output gets a default first so no path through this block infers a latch.
        bram_addr_out  = 8'h00;
        bram_we_out    = 1'b0;
        bram_wdata_out = 8'h00;
        if (video_active_in) begin
            bram_addr_out = video_addr_in;
        end else if (state == CLEAR) begin
            bram_addr_out = clear_cnt;
            bram_we_out   = 1'b1;
        end else if (state == XOR_WB) begin
            bram_addr_out  = addr_q;
            bram_we_out    = 1'b1;
            bram_wdata_out = old_q ^ wdata_q;
        end else if (accept) begin
            bram_addr_out = cpu_addr_in;
            if (cpu_op_in == OP_WRITE) begin
                bram_we_out    = 1'b1;
                bram_wdata_out = cpu_wdata_in;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state         <= IDLE;
            addr_q        <= 8'h00;
            wdata_q       <= 8'h00;
            old_q         <= 8'h00;
            clear_cnt     <= 8'h00;
            is_xor_q      <= 1'b0;
            clear_pending <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            tag_q         <= '0;
        end else begin
            // NOTE: non-blocking assignments only, so every register samples pre-edge values.
            tag_q[0] <= cpu_read_issue;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end

            done_q <= 1'b0;
            if (done_q) begin
                busy_q <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (clear_start_in || clear_pending) begin
                        state         <= CLEAR;
                        clear_cnt     <= 8'h00;
                        clear_pending <= 1'b0;
                        busy_q        <= 1'b1;
                    end else if (accept) begin
                        addr_q   <= cpu_addr_in;
                        wdata_q  <= cpu_wdata_in;
                        is_xor_q <= (cpu_op_in == OP_XOR);
                        if (cpu_op_in != OP_WRITE) begin
                            state <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (clear_start_in) begin
                        clear_pending <= 1'b1;
                        busy_q        <= 1'b1;
                    end
                    if (rd_return) begin
                        if (is_xor_q) begin
                            old_q <= bram_rdata_in;
                            state <= XOR_WB;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                XOR_WB: begin
                    if (clear_start_in) begin
                        clear_pending <= 1'b1;
                        busy_q        <= 1'b1;
                    end
                    if (!video_active_in) begin
                        state <= IDLE;
                    end
                end
                CLEAR: begin
                    // Video cycles stall the sweep; the write only happens when video is idle.
                    if (!video_active_in) begin
                        clear_cnt <= clear_cnt + 8'd1;
                        if (clear_cnt == 8'hFF) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Directed bench for framebuffer_arbiter with a behavioural BRAM of matching read latency.
module tb_framebuffer_arbiter;

    localparam int LAT = 2;
    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_XOR   = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       video_active_in;
    logic [7:0] video_addr_in;
    logic [7:0] video_data_out;
    logic       cpu_req_valid_in;
    logic       cpu_req_ready_out;
    logic [1:0] cpu_op_in;
    logic [7:0] cpu_addr_in;
    logic [7:0] cpu_wdata_in;
    logic       cpu_rvalid_out;
    logic [7:0] cpu_rdata_out;
    logic       cpu_collision_out;
    logic       clear_start_in;
    logic       clear_busy_out;
    logic       clear_done_out;
    logic [7:0] bram_addr_out;
    logic       bram_we_out;
    logic [7:0] bram_wdata_out;
    logic [7:0] bram_rdata_in;

    int n_checks = 0;
    int n_pass   = 0;

    framebuffer_arbiter #(.READ_LATENCY(LAT)) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .video_active_in   (video_active_in),
        .video_addr_in     (video_addr_in),
        .video_data_out    (video_data_out),
        .cpu_req_valid_in  (cpu_req_valid_in),
        .cpu_req_ready_out (cpu_req_ready_out),
        .cpu_op_in         (cpu_op_in),
        .cpu_addr_in       (cpu_addr_in),
        .cpu_wdata_in      (cpu_wdata_in),
        .cpu_rvalid_out    (cpu_rvalid_out),
        .cpu_rdata_out     (cpu_rdata_out),
        .cpu_collision_out (cpu_collision_out),
        .clear_start_in    (clear_start_in),
        .clear_busy_out    (clear_busy_out),
        .clear_done_out    (clear_done_out),
        .bram_addr_out     (bram_addr_out),
        .bram_we_out       (bram_we_out),
        .bram_wdata_out    (bram_wdata_out),
        .bram_rdata_in     (bram_rdata_in)
    );

    always #5 clk_in = ~clk_in;

    // BRAM model: read-first, data appears LAT cycles after the address.
    logic [7:0]  mem     [256] = '{default: 8'h00};
    logic [7:0]  rd_pipe [LAT] = '{default: 8'h00};
    logic [15:0] wr_log  [$];

    always @(posedge clk_in) begin
        if (bram_we_out) begin
            mem[bram_addr_out] <= bram_wdata_out;
            wr_log.push_back({bram_addr_out, bram_wdata_out});
        end
        rd_pipe[0] <= mem[bram_addr_out];
        for (int i = 1; i < LAT; i++) begin
            rd_pipe[i] <= rd_pipe[i-1];
        end
    end
    assign bram_rdata_in = rd_pipe[LAT-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk_in);
    endtask

    // Presents a request in cycle T; returns at the falling edge of T+1 with valid dropped.
    task automatic cpu_issue(input logic [1:0] op, input logic [7:0] addr,
                             input logic [7:0] wdata, input string tag);
        cpu_req_valid_in = 1'b1;
        cpu_op_in        = op;
        cpu_addr_in      = addr;
        cpu_wdata_in     = wdata;
        #1;
        check({tag, "_ready"}, cpu_req_ready_out, 1);
        check({tag, "_we"},    bram_we_out, (op == OP_WRITE));
        check({tag, "_addr"},  bram_addr_out, addr);
        check({tag, "_wdata"}, bram_wdata_out, (op == OP_WRITE) ? wdata : 8'h00);
        next_cycle();
        cpu_req_valid_in = 1'b0;
        cpu_addr_in      = ~addr;
        cpu_wdata_in     = ~wdata;
    endtask

    task automatic cpu_read(input logic [1:0] op, input logic [7:0] addr,
                            input logic [7:0] exp, input string tag);
        cpu_issue(op, addr, 8'h00, tag);
        #1;
        check({tag, "_rvalid_early"}, cpu_rvalid_out, 0);
        next_cycle();
        #1;
        check({tag, "_rvalid"}, cpu_rvalid_out, 1);
        check({tag, "_rdata"},  cpu_rdata_out, exp);
        next_cycle();
    endtask

    task automatic cpu_xor(input logic [7:0] addr, input logic [7:0] wdata, input logic [7:0] old,
                           input logic coll, input logic [7:0] new_val, input string tag);
        cpu_issue(OP_XOR, addr, wdata, tag);
        #1;
        check({tag, "_rvalid_early"}, cpu_rvalid_out, 0);
        next_cycle();
        #1;
        check({tag, "_rvalid"}, cpu_rvalid_out, 1);
        check({tag, "_old"},    cpu_rdata_out, old);
        check({tag, "_coll"},   cpu_collision_out, coll);
        next_cycle();
        #1;
        check({tag, "_wb_we"},    bram_we_out, 1);
        check({tag, "_wb_addr"},  bram_addr_out, addr);
        check({tag, "_wb_wdata"}, bram_wdata_out, new_val);
        next_cycle();
    endtask

    task automatic check_clear_log(input int base, input string tag);
        int bad;
        bad = 0;
        check({tag, "_count"}, wr_log.size() - base, 256);
        for (int i = 0; i < 256 && base + i < wr_log.size(); i++) begin
            if (wr_log[base + i] !== {i[7:0], 8'h00}) bad++;
        end
        check({tag, "_order"}, bad, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        int base;
        int bad;
        bit seen;

        rst_in           = 1'b0;
        video_active_in  = 1'b0;
        video_addr_in    = 8'h00;
        cpu_req_valid_in = 1'b0;
        cpu_op_in        = OP_READ;
        cpu_addr_in      = 8'h00;
        cpu_wdata_in     = 8'h00;
        clear_start_in   = 1'b0;

        repeat (2) next_cycle();
        #1;
        check("rst_rvalid", cpu_rvalid_out, 0);
        check("rst_rdata",  cpu_rdata_out, 0);
        check("rst_coll",   cpu_collision_out, 0);
        check("rst_busy",   clear_busy_out, 0);
        check("rst_done",   clear_done_out, 0);
        check("rst_we",     bram_we_out, 0);
        check("rst_ready",  cpu_req_ready_out, 1);
        next_cycle();
        rst_in = 1'b1;

        // Write then read back, XOR with and without collision, reserved op as read.
        cpu_issue(OP_WRITE, 8'h10, 8'h5A, "wr10");
        cpu_read(OP_READ, 8'h10, 8'h5A, "rd10");
        cpu_issue(OP_WRITE, 8'h20, 8'hF0, "wr20");
        cpu_xor(8'h20, 8'h3C, 8'hF0, 1'b1, 8'hCC, "xor20");
        cpu_read(OP_READ, 8'h20, 8'hCC, "rd20");
        cpu_issue(OP_WRITE, 8'h30, 8'h0F, "wr30");
        cpu_xor(8'h30, 8'hF0, 8'h0F, 1'b0, 8'hFF, "xor30");
        cpu_read(OP_RSVD, 8'h30, 8'hFF, "rsv30");

        // Video takes the port right after an XOR is issued.
        cpu_issue(OP_WRITE, 8'h40, 8'h81, "wr40");
        cpu_issue(OP_WRITE, 8'h50, 8'h77, "wr50");
        cpu_issue(OP_XOR, 8'h40, 8'h01, "vx");
        video_active_in = 1'b1;
        video_addr_in   = 8'h50;
        #1;
        check("vx_t1_addr", bram_addr_out, 8'h50);
        check("vx_t1_we",   bram_we_out, 0);
        next_cycle();
        #1;
        check("vx_rvalid", cpu_rvalid_out, 1);
        check("vx_old",    cpu_rdata_out, 8'h81);
        check("vx_coll",   cpu_collision_out, 1);
        next_cycle();
        #1;
        check("vx_t3_we",    bram_we_out, 0);
        check("vx_t3_vdata", video_data_out, 8'h77);
        check("vx_t3_ready", cpu_req_ready_out, 0);
        next_cycle();
        #1;
        check("vx_t4_we",    bram_we_out, 0);
        check("vx_t4_vdata", video_data_out, 8'h77);
        next_cycle();
        video_active_in = 1'b0;
        #1;
        check("vx_wb_we",    bram_we_out, 1);
        check("vx_wb_addr",  bram_addr_out, 8'h40);
        check("vx_wb_wdata", bram_wdata_out, 8'h80);
        next_cycle();
        cpu_read(OP_READ, 8'h40, 8'h80, "rd40");

        // A plain read still completes when video grabs the port behind it.
        cpu_issue(OP_READ, 8'h10, 8'h00, "vr");
        video_active_in = 1'b1;
        video_addr_in   = 8'h40;
        next_cycle();
        #1;
        check("vr_rvalid", cpu_rvalid_out, 1);
        check("vr_rdata",  cpu_rdata_out, 8'h5A);
        next_cycle();
        video_active_in = 1'b0;

        // Clear and a CPU request arrive together: clear wins, ready stays low throughout.
        clear_start_in   = 1'b1;
        cpu_req_valid_in = 1'b1;
        cpu_op_in        = OP_WRITE;
        cpu_addr_in      = 8'h99;
        cpu_wdata_in     = 8'h11;
        #1;
        check("cs_ready", cpu_req_ready_out, 0);
        check("cs_we",    bram_we_out, 0);
        base = wr_log.size();
        next_cycle();
        clear_start_in = 1'b0;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            #1;
            if (cpu_req_ready_out !== 1'b0 || clear_busy_out !== 1'b1 || clear_done_out !== 1'b0) bad++;
            next_cycle();
        end
        cpu_req_valid_in = 1'b0;
        #1;
        check("cs_during", bad, 0);
        check("cs_done",   clear_done_out, 1);
        check("cs_busy",   clear_busy_out, 1);
        check("cs_we_end", bram_we_out, 0);
        check_clear_log(base, "cs");
        next_cycle();
        #1;
        check("cs_done_gone", clear_done_out, 0);
        check("cs_busy_gone", clear_busy_out, 0);
        next_cycle();
        cpu_read(OP_READ, 8'h10, 8'h00, "cs_rd10");

        // Clear requested while a read is in flight, with a short video stall mid-sweep.
        cpu_issue(OP_WRITE, 8'h60, 8'h3C, "wr60");
        cpu_issue(OP_READ, 8'h60, 8'h00, "rc");
        clear_start_in = 1'b1;
        #1;
        check("rc_rvalid_early", cpu_rvalid_out, 0);
        next_cycle();
        clear_start_in = 1'b0;
        #1;
        check("rc_rvalid", cpu_rvalid_out, 1);
        check("rc_rdata",  cpu_rdata_out, 8'h3C);
        check("rc_busy",   clear_busy_out, 1);
        next_cycle();
        #1;
        check("rc_pend_ready", cpu_req_ready_out, 0);
        check("rc_pend_we",    bram_we_out, 0);
        base = wr_log.size();
        next_cycle();
        #1;
        check("rc_first_we",   bram_we_out, 1);
        check("rc_first_addr", bram_addr_out, 8'h00);
        seen = 1'b0;
        for (int n = 0; n < 400; n++) begin
            next_cycle();
            video_active_in = (n >= 50 && n < 53);
            video_addr_in   = 8'h60;
            #1;
            if (clear_done_out) begin
                seen = 1'b1;
                break;
            end
        end
        video_active_in = 1'b0;
        check("rc_done_seen", seen, 1);
        check_clear_log(base, "rc");
        next_cycle();
        cpu_read(OP_READ, 8'h60, 8'h00, "rc_rd60");

        // Reset in the middle of a clear, at counter 100.
        cpu_issue(OP_WRITE, 8'hC8, 8'hAB, "wrc8");
        clear_start_in = 1'b1;
        next_cycle();
        clear_start_in = 1'b0;
        repeat (100) next_cycle();
        #1;
        check("rm_addr", bram_addr_out, 8'd100);
        check("rm_we",   bram_we_out, 1);
        rst_in = 1'b0;
        #1;
        check("rm_busy",   clear_busy_out, 0);
        check("rm_done",   clear_done_out, 0);
        check("rm_rvalid", cpu_rvalid_out, 0);
        check("rm_rdata",  cpu_rdata_out, 0);
        check("rm_coll",   cpu_collision_out, 0);
        check("rm_we_rst", bram_we_out, 0);
        base = wr_log.size();
        repeat (2) next_cycle();
        rst_in = 1'b1;
        repeat (3) next_cycle();
        #1;
        check("rm_no_writes", wr_log.size() - base, 0);
        check("rm_ready",     cpu_req_ready_out, 1);
        check("rm_busy_post", clear_busy_out, 0);
        next_cycle();
        cpu_read(OP_READ, 8'hC8, 8'hAB, "rm_rdc8");
        cpu_read(OP_READ, 8'h63, 8'h00, "rm_rd63");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
